mealy_engine_sched: RTL and testbench

- Round-robin scheduler that time-shares one 4-state Mealy sequence engine among NREQ requesters.
- Each granted job is a W-bit word, fed to the engine LSB-first, one bit per clock.
- The engine's y output is collected into a W-bit result word and returned with the requester ID.
- Sits between requester blocks and the engine's x/rst/y pins; the engine has no enable and steps on every clock.

---
 rtl/mealy_engine_sched.sv | 143 ++++++++++++++
 tb/tb_mealy_engine_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_engine_sched.sv
// Round-robin scheduler that time-shares one serial Mealy engine among NREQ requesters.
// Each granted job word is shifted out LSB-first and the engine's y bits are collected back.
module mealy_engine_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic [W-1:0]      result,
    output logic              fsm_rst,
    output logic              fsm_x,
    input  logic              fsm_y
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_result;
    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_count;
    logic            r_fsm_rst;
    logic            r_fsm_x;

    logic            w_found;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [W-1:0]    w_data;

    // Rotating priority search starting at r_ptr.
    always_comb begin
        int unsigned j;
        j         = 0;
        w_found   = 1'b0;
        w_idx     = '0;
        w_ptr_nxt = '0;
        w_data    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(r_ptr) + i) % NREQ;
            if (!w_found && req[j]) begin
                w_found   = 1'b1;
                w_idx     = IDW'(j);
                w_ptr_nxt = IDW'((j + 1) % NREQ);
                w_data    = req_data[j*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_id      <= '0;
            r_result  <= '0;
            r_shift   <= '0;
            r_count   <= '0;
            r_fsm_rst <= 1'b1;
            r_fsm_x   <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_CLR;
                        r_gnt   <= NREQ'(1) << w_idx;
                        r_shift <= w_data;
                        r_id    <= w_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_busy  <= 1'b1;
                        r_fsm_x <= w_data[0];
                    end
                end
                S_CLR: begin
                    r_state   <= S_SHIFT;
                    r_count   <= '0;
                    r_fsm_rst <= 1'b0;
                    r_fsm_x   <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                end
                S_SHIFT: begin
                    // y for data bit k-1 is visible during count k.
                    if (r_count != '0) begin
                        r_result <= {fsm_y, r_result[W-1:1]};
                    end
                    if (r_count == CNT_LAST) begin
                        r_state <= S_DRAIN;
                        r_fsm_x <= 1'b0;
                    end else begin
                        r_count <= r_count + 1'b1;
                        r_fsm_x <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_DRAIN: begin
                    r_result <= {fsm_y, r_result[W-1:1]};
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_fsm_rst <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_fsm_rst <= 1'b1;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_id;
    assign result  = r_result;
    assign fsm_rst = r_fsm_rst;
    assign fsm_x   = r_fsm_x;

endmodule

// File: tb/tb_mealy_engine_sched.sv
// Directed bench for mealy_engine_sched with a behavioural model of the 4-state engine.
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
module tb_mealy_engine_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [W-1:0]      result;
    logic              fsm_rst;
    logic              fsm_x;
    logic              fsm_y;

    int n_cmp;
    int n_err;

    mealy_engine_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .fsm_rst  (fsm_rst),
        .fsm_x    (fsm_x),
        .fsm_y    (fsm_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: registered state and y, synchronous active-high reset.
    logic [1:0] e_s;
    logic       e_y;
    always_ff @(posedge clk) begin
        if (fsm_rst) begin
            e_s <= 2'd0;
            e_y <= 1'b0;
        end else begin
            case (e_s)
                2'd0: begin e_s <= fsm_x ? 2'd0 : 2'd1; e_y <= fsm_x ? 1'b1 : 1'b0; end
                2'd1: begin e_s <= fsm_x ? 2'd3 : 2'd2; e_y <= fsm_x ? 1'b0 : 1'b1; end
                2'd2: begin e_s <= fsm_x ? 2'd1 : 2'd0; e_y <= fsm_x ? 1'b0 : 1'b1; end
                default: begin e_s <= fsm_x ? 2'd2 : 2'd3; e_y <= fsm_x ? 1'b1 : 1'b0; end
            endcase
        end
    end
    assign fsm_y = e_y;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_done_id"}, 32'(done_id), 32'h0);
        chk({tag, "_result"}, 32'(result), 32'h0);
        chk({tag, "_fsm_rst"}, 32'(fsm_rst), 32'h1);
        chk({tag, "_fsm_x"}, 32'(fsm_x), 32'h0);
    endtask

    // Waits (bounded) for done; returns the number of falling edges waited.
    task automatic wait_done(output int cnt, output int bad_rst);
        cnt     = 0;
        bad_rst = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (fsm_rst !== 1'b0) bad_rst++;
        end
    endtask

    // Single job from IDLE: req held until gnt, then dropped.
    task automatic run_job(input int id, input logic [7:0] data, input logic [7:0] exp);
        int cnt;
        int bad_rst;
        req_data[id*W +: W] = data;
        req[id] = 1'b1;
        @(negedge clk);
        chk("job_gnt", 32'(gnt), 32'(1) << id);
        chk("job_clr_fsm_rst", 32'(fsm_rst), 32'h1);
        chk("job_clr_busy", 32'(busy), 32'h1);
        chk("job_clr_fsm_x", 32'(fsm_x), 32'(data[0]));
        req[id] = 1'b0;
        wait_done(cnt, bad_rst);
        chk("job_latency", 32'(cnt), 32'(W + 2));
        chk("job_fsm_rst_low", 32'(bad_rst), 32'h0);
        chk("job_result", 32'(result), 32'(exp));
        chk("job_done_id", 32'(done_id), 32'(id));
        chk("job_done_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("job_done_pulse", 32'(done), 32'h0);
        chk("job_idle_busy", 32'(busy), 32'h0);
        chk("job_idle_fsm_rst", 32'(fsm_rst), 32'h1);
        chk("job_result_hold", 32'(result), 32'(exp));
    endtask

    logic [7:0] rr_exp[NREQ];
    int         rr_order[5];

    initial begin
        int cnt;
        int bad_rst;
        int ngnt;
        int last_done;
        int gidx;
        int saw_done;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{id: 0, data: 8'hFF, exp: 8'hFF};
        vecs[1] = '{id: 2, data: 8'h00, exp: 8'hB6};
        vecs[2] = '{id: 1, data: 8'h01, exp: 8'h6D};
        vecs[3] = '{id: 3, data: 8'h0F, exp: 8'h6F};
        vecs[4] = '{id: 1, data: 8'hF0, exp: 8'h26};
        rr_exp[0] = 8'hFF;
        rr_exp[1] = 8'h6D;
        rr_exp[2] = 8'hB6;
        rr_exp[3] = 8'h6F;
        rr_order[0] = 0;
        rr_order[1] = 1;
        rr_order[2] = 2;
        rr_order[3] = 3;
        rr_order[4] = 0;

        rst      = 1'b0;
        req      = '0;
        req_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].id, vecs[v].data, vecs[v].exp);
        end

        // Round-robin with all requests held from reset.
        rst = 1'b0;
        req = '1;
        req_data = {8'h0F, 8'h00, 8'h01, 8'hFF};
        @(negedge clk);
        rst = 1'b1;
        ngnt = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 70 && ngnt < 5; cyc++) begin
            @(negedge clk);
            if (gnt != '0) begin
                gidx = -1;
                for (int b = 0; b < NREQ; b++) if (gnt[b]) gidx = b;
                chk("rr_gnt_onehot", 32'($countones(gnt)), 32'h1);
                chk("rr_order", 32'(gidx), 32'(rr_order[ngnt]));
                ngnt++;
            end
            if (done) begin
                if (last_done >= 0) chk("rr_done_spacing", 32'(cyc - last_done), 32'd12);
                chk("rr_result", 32'(result), 32'(rr_exp[done_id]));
                last_done = cyc;
            end
        end
        chk("rr_grant_count", 32'(ngnt), 32'd5);

        // Reset during SHIFT count 4: abort, then the held request is re-granted.
        rst = 1'b0;
        req = '0;
        req_data = '0;
        @(negedge clk);
        rst = 1'b1;
        req_data[2*W +: W] = 8'h00;
        req[2] = 1'b1;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'h4);
        saw_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        rst = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        if (done) saw_done++;
        rst = 1'b1;
        cnt = 0;
        while (gnt == '0 && cnt < 10) begin
            @(negedge clk);
            if (done) saw_done++;
            cnt++;
        end
        chk("abort_no_done", 32'(saw_done), 32'h0);
        chk("abort_regnt", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        wait_done(cnt, bad_rst);
        chk("abort_latency", 32'(cnt), 32'(W + 2));
        chk("abort_result", 32'(result), 32'hB6);
        chk("abort_done_id", 32'(done_id), 32'h2);
        @(negedge clk);

        // req/req_data changes during a job are ignored.
        req_data[3*W +: W] = 8'h0F;
        req[3] = 1'b1;
        @(negedge clk);
        chk("mid_gnt3", 32'(gnt), 32'h8);
        @(negedge clk);
        @(negedge clk);
        req[3] = 1'b0;
        req_data[3*W +: W] = 8'h00;
        req_data[1*W +: W] = 8'hF0;
        req[1] = 1'b1;
        wait_done(cnt, bad_rst);
        chk("mid_latency3", 32'(cnt), 32'(W));
        chk("mid_result3", 32'(result), 32'h6F);
        chk("mid_done_id3", 32'(done_id), 32'h3);
        @(negedge clk);
        chk("mid_idle_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("mid_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        req_data[1*W +: W] = 8'h55;
        wait_done(cnt, bad_rst);
        chk("mid_latency1", 32'(cnt), 32'(W + 2));
        chk("mid_result1", 32'(result), 32'h26);
        chk("mid_done_id1", 32'(done_id), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
